imem_prog: RTL and testbench
============================

Name: imem_prog

Overview:
Parametrised, run-time-loadable instruction memory for the LEGv8 single-cycle/multicycle core; next generation of the fixed 64x32 ROM.
- Depth, word width and fetch latency are configurable.
- A program-load port lets the bench or debug logic write the image before release.
- Fetches use a req/valid handshake with a fixed latency and flag misaligned or out-of-range PCs instead of aliasing.

Parameters:
N, 32, instruction word width in bits.
ADDR_W, 6, word-address width; depth = 2^ADDR_W words.
PC_W, 64, width of the byte-address PC input.
LATENCY, 1, cycles from accepted fetch to fetch_valid; legal range 1..4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
prog_mode  in  1  1 = load mode: fetches blocked, writes enabled.
wr_en  in  1  write strobe, honoured only in load mode while IDLE.
wr_addr  in  ADDR_W  word address for load.
wr_data  in  N  word to load.
clear  in  1  one-cycle pulse: invalidate all words (load mode, IDLE only).
fetch_req  in  1  fetch request.
pc  in  PC_W  byte address of the instruction.
fetch_ready  out  1  block can accept fetch_req this cycle.
fetch_valid  out  1  one-cycle pulse: q and error flags valid.
q  out  N  fetched instruction.
misaligned  out  1  pc[1:0] != 0 for the returned fetch.
out_of_range  out  1  pc beyond depth for the returned fetch.

Behaviour:
- Reset (reset=0, async): state=IDLE; fetch_valid=0, q=0, misaligned=0, out_of_range=0; all per-word valid bits=0. Array contents need not be reset.
- Reading a word whose valid bit is 0 returns 0 (matches the old ROM zero-fill default).
- fetch_ready = (state==IDLE) && !prog_mode.
- Word index = pc[ADDR_W+1:2].
- out_of_range = |pc[PC_W-1:ADDR_W+2].
- misaligned = |pc[1:0].
- If either flag is set, q=0.
- Fetch FSM:
  - IDLE: fetch_req && fetch_ready -> capture pc, load latency counter with LATENCY-1, go to WAIT.
  - WAIT: counter==0 -> next edge drives q/flags and fetch_valid=1, go to IDLE; otherwise decrement.
  - Net effect: fetch_valid rises exactly LATENCY edges after the accepting edge.
- q and the flags hold their value after fetch_valid drops, until the next response.
- fetch_req while not ready is ignored, not queued. The requester must hold or re-issue it.
- Back-to-back throughput: one fetch per LATENCY+1 cycles. Re-request in the cycle after fetch_valid is accepted.
- pc is sampled only at acceptance; later pc changes do not affect the in-flight fetch.
- Load mode:
  - wr_en at an edge with prog_mode=1 && state==IDLE writes mem[wr_addr]=wr_data and sets valid[wr_addr].
  - wr_en in any other condition is ignored.
- clear (same qualification as wr_en) zeroes all valid bits in one cycle. clear and wr_en in the same cycle: clear first, then the write, so the written word ends valid.
- prog_mode rising while a fetch is in WAIT: the fetch completes normally; writes are ignored until IDLE.
- Reset mid-fetch: the fetch is aborted, no fetch_valid, all flags and outputs return to reset values.

Test Plan:
- Reset, then fetch pc=0 with no program loaded, LATENCY=1 -> fetch_valid one cycle after accept, q=32'h00000000, both flags 0.
- Load mode writes mem[0]=32'hf8000000, mem[1]=32'hf8008001, mem[3]=32'hd61f0300; exit load mode; fetch pc=0,4,12 -> q=f8000000, f8008001, d61f0300; fetch pc=8 -> q=0.
- LATENCY=3, fetch pc=4 -> fetch_ready=0 for 3 cycles, fetch_valid exactly 3 edges after accept; fetch_req held during WAIT is not re-accepted early.
- pc=0x6 -> misaligned=1, q=0. pc=0x100 (ADDR_W=6) -> out_of_range=1, q=0. pc=0xFC -> word 63, no flags.
- Fetch in flight, raise prog_mode and assert wr_en to that word -> fetch returns the old data, the write is dropped; a write issued after IDLE succeeds. clear+wr_en(addr 5, 32'h1400000b) together -> only word 5 reads non-zero.
- Assert reset low mid-WAIT -> fetch_valid never pulses, q=0, all valid bits cleared; after release a fetch of pc=0 returns 0.

Source files
------------

// File: rtl/imem_prog_if.sv
// Fetch/load bus for the loadable instruction memory; the requester drives
// through master, the memory sits on slave.
interface imem_prog_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int PC_W   = 64
);
  logic              prog_mode;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic              clear;
  logic              fetch_req;
  logic [PC_W-1:0]   pc;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [N-1:0]      q;
  logic              misaligned;
  logic              out_of_range;

  modport master (
    output prog_mode, wr_en, wr_addr, wr_data, clear, fetch_req, pc,
    input  fetch_ready, fetch_valid, q, misaligned, out_of_range
  );

  modport slave (
    input  prog_mode, wr_en, wr_addr, wr_data, clear, fetch_req, pc,
    output fetch_ready, fetch_valid, q, misaligned, out_of_range
  );
endinterface

// File: rtl/imem_prog.sv
// Run-time loadable instruction memory with per-word valid bits and a
// fixed-latency req/valid fetch port that flags bad PCs instead of aliasing.
module imem_prog #(
  parameter int N       = 32,
  parameter int ADDR_W  = 6,
  parameter int PC_W    = 64,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  imem_prog_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_next;
  logic [1:0]        cnt, cnt_next;
  logic              accept, respond, wr_ok;
  logic [PC_W-1:0]   pc_cap;
  logic [ADDR_W-1:0] idx;
  logic              mis_flag, oor_flag;
  logic [N-1:0]      rd_word;
  logic [N-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  assign bus.fetch_ready = (state == IDLE) && !bus.prog_mode;
  assign wr_ok           = bus.prog_mode && (state == IDLE);

  assign idx      = pc_cap[ADDR_W+1:2];
  assign mis_flag = |pc_cap[1:0];
  assign oor_flag = |pc_cap[PC_W-1:ADDR_W+2];
  assign rd_word  = valid[idx] ? mem[idx] : '0;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    respond    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.fetch_req && !bus.prog_mode) begin
          accept     = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          respond    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      pc_cap <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) pc_cap <= bus.pc;
    end
  end

  // Response registers hold their value between fetches; only fetch_valid pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.fetch_valid  <= 1'b0;
      bus.q            <= '0;
      bus.misaligned   <= 1'b0;
      bus.out_of_range <= 1'b0;
    end else begin
      bus.fetch_valid <= respond;
      if (respond) begin
        bus.q            <= (mis_flag || oor_flag) ? '0 : rd_word;
        bus.misaligned   <= mis_flag;
        bus.out_of_range <= oor_flag;
      end
    end
  end

  // Clear acts before the write so a simultaneous write survives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (wr_ok) begin
      if (bus.clear) valid <= '0;
      if (bus.wr_en) valid[bus.wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end
endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog: one instance at LATENCY=1 and one at
// LATENCY=3, checked against an array model of the program image.
module tb_imem_prog;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int checks = 0;
  int failures = 0;

  logic [31:0] mm [2][64];
  bit          mv [2][64];

  imem_prog_if #(.N(32), .ADDR_W(6), .PC_W(64)) ia ();
  imem_prog_if #(.N(32), .ADDR_W(6), .PC_W(64)) ib ();

  imem_prog #(.N(32), .ADDR_W(6), .PC_W(64), .LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ia)
  );
  imem_prog #(.N(32), .ADDR_W(6), .PC_W(64), .LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ib)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected fetch result straight from the memory map: 4-byte words, 256 bytes total.
  function automatic logic [31:0] model_q(input int w, input logic [63:0] p);
    int i;
    if ((p % 4) != 0 || p >= 64'd256) return 32'h0;
    i = int'(p / 4);
    return mv[w][i] ? mm[w][i] : 32'h0;
  endfunction

  task automatic set_in(input int w, input logic pm, input logic we, input logic [5:0] wa,
                        input logic [31:0] wd, input logic cl, input logic fr,
                        input logic [63:0] p);
    if (w == 0) begin
      ia.prog_mode = pm; ia.wr_en = we; ia.wr_addr = wa; ia.wr_data = wd;
      ia.clear = cl; ia.fetch_req = fr; ia.pc = p;
    end else begin
      ib.prog_mode = pm; ib.wr_en = we; ib.wr_addr = wa; ib.wr_data = wd;
      ib.clear = cl; ib.fetch_req = fr; ib.pc = p;
    end
  endtask

  function automatic logic rdy(input int w); return w == 0 ? ia.fetch_ready : ib.fetch_ready; endfunction
  function automatic logic vld(input int w); return w == 0 ? ia.fetch_valid : ib.fetch_valid; endfunction
  function automatic logic [31:0] qv(input int w); return w == 0 ? ia.q : ib.q; endfunction
  function automatic logic mis(input int w); return w == 0 ? ia.misaligned : ib.misaligned; endfunction
  function automatic logic oor(input int w); return w == 0 ? ia.out_of_range : ib.out_of_range; endfunction

  task automatic load(input int w, input logic [5:0] a, input logic [31:0] d, input logic cl);
    @(negedge clk);
    set_in(w, 1'b1, 1'b1, a, d, cl, 1'b0, 64'h0);
    @(negedge clk);
    set_in(w, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 64'h0);
    if (cl) for (int i = 0; i < 64; i++) mv[w][i] = 1'b0;
    mm[w][a] = d;
    mv[w][a] = 1'b1;
  endtask

  task automatic check_outputs(input string tag, input int w, input logic [63:0] p);
    check({tag, "_q"}, qv(w), model_q(w, p));
    check({tag, "_mis"}, mis(w), (p % 4) != 0);
    check({tag, "_oor"}, oor(w), p >= 64'd256);
  endtask

  task automatic fetch(input int w, input string tag, input logic [63:0] p, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    set_in(w, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, p);
    #1;
    check({tag, "_ready"}, rdy(w), 1'b1);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, {$urandom, $urandom});
    got = 1'b0;
    lat = 0;
    while (!got && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
      if (vld(w)) got = 1'b1;
    end
    check({tag, "_lat"}, got ? lat : -1, exp_lat);
    if (got) check_outputs(tag, w, p);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_vdrop"}, vld(w), 1'b0);
    check({tag, "_hold"}, qv(w), model_q(w, p));
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    case ($urandom_range(0, 3))
      0, 1: p = {56'h0, 6'($urandom_range(0, 63)), 2'b00};
      2:    p = {56'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      default: begin p = {$urandom, $urandom}; p[8] = 1'b1; end
    endcase
    return p;
  endfunction

  initial begin
    logic [31:0] old_word;
    for (int i = 0; i < 64; i++) begin mv[0][i] = 0; mv[1][i] = 0; mm[0][i] = 0; mm[1][i] = 0; end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check("rst_valid", vld(w), 1'b0);
      check("rst_q", qv(w), 32'h0);
      check("rst_mis", mis(w), 1'b0);
      check("rst_oor", oor(w), 1'b0);
      check("rst_ready", rdy(w), 1'b1);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;

    $display("[TB] empty image fetch");
    fetch(0, "a_empty", 64'h0, 1);

    $display("[TB] directed program load");
    load(0, 6'd0, 32'hf8000000, 1'b0);
    load(0, 6'd1, 32'hf8008001, 1'b0);
    load(0, 6'd3, 32'hd61f0300, 1'b0);
    fetch(0, "a_pc0", 64'h0, 1);
    fetch(0, "a_pc4", 64'h4, 1);
    fetch(0, "a_pc12", 64'hc, 1);
    fetch(0, "a_pc8", 64'h8, 1);

    $display("[TB] address boundaries");
    load(0, 6'd63, 32'h8b020020, 1'b0);
    fetch(0, "a_mis6", 64'h6, 1);
    fetch(0, "a_oor100", 64'h100, 1);
    fetch(0, "a_pcfc", 64'hfc, 1);
    fetch(0, "a_oor_top", 64'h8000_0000_0000_0000, 1);

    $display("[TB] write during in-flight fetch");
    load(0, 6'd2, 32'h91000421, 1'b0);
    old_word = mm[0][2];
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 64'h8);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, 6'd2, 32'hdeadbeef, 1'b0, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    check("inflight_valid", vld(0), 1'b1);
    check("inflight_q", qv(0), old_word);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 64'h0);
    fetch(0, "a_dropped", 64'h8, 1);
    load(0, 6'd2, 32'hcafef00d, 1'b0);
    fetch(0, "a_late_wr", 64'h8, 1);

    $display("[TB] clear with simultaneous write");
    load(0, 6'd5, 32'h1400000b, 1'b1);
    for (int i = 0; i < 64; i++) fetch(0, "a_clr", 64'(i * 4), 1);

    $display("[TB] randomized load/fetch mix");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0)
        load(0, 6'($urandom_range(0, 63)), $urandom, $urandom_range(0, 9) == 0);
      else
        fetch(0, "a_rand", rand_pc(), 1);
    end

    $display("[TB] latency 3 instance");
    load(1, 6'd1, 32'haa55aa55, 1'b0);
    fetch(1, "b_pc4", 64'h4, 3);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 64'h4);
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("b_hold_ready", rdy(1), 1'b0);
        check("b_hold_valid", vld(1), 1'b0);
        @(posedge clk);
      end
      #1;
      check("b_hold_resp", vld(1), 1'b1);
      check("b_hold_q", qv(1), 32'haa55aa55);
      @(negedge clk);
      check("b_idle_ready", rdy(1), 1'b1);
      if (r == 0) @(posedge clk);
    end
    set_in(1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 64'h0);
    fetch(1, "b_mis", 64'h6, 3);

    $display("[TB] reset during wait");
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1, 64'h4);
    @(posedge clk);
    @(negedge clk);
    set_in(1, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0, 64'h0);
    rst_b = 1'b0;
    #1;
    check("b_rst_q", qv(1), 32'h0);
    check("b_rst_mis", mis(1), 1'b0);
    check("b_rst_oor", oor(1), 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_rst_novalid", vld(1), 1'b0);
    end
    rst_b = 1'b1;
    for (int i = 0; i < 64; i++) mv[1][i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_post_novalid", vld(1), 1'b0);
    end
    fetch(1, "b_post_pc0", 64'h0, 3);
    fetch(1, "b_post_pc4", 64'h4, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
